// File: rtl/serial_add_if.sv
// Handshake and operand/result bundle for the digit-serial adder.
// The master drives the request; the slave (the adder) returns status and result.
interface serial_add_if #(
    parameter int unsigned WIDTH = 16
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             overflow;

    modport master (
        output start, a, b, cin,
        input  busy, done, sum, cout, overflow
    );

    modport slave (
        input  start, a, b, cin,
        output busy, done, sum, cout, overflow
    );
endinterface

// File: rtl/serial_add.sv
// Multi-cycle adder: {cout,sum} = a + b + cin, DIGIT bits per clock through one
// DIGIT-wide adder slice and a registered carry, over WIDTH/DIGIT cycles.
module serial_add #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned DIGIT = 1
) (
    input logic         clk,
    input logic         rst,
    serial_add_if.slave bus
);
    localparam int unsigned N    = WIDTH / DIGIT;
    localparam int unsigned CntW = (N > 1) ? $clog2(N) : 1;

    generate
        if (WIDTH < 1 || DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_bad_params
            $error("serial_add: WIDTH must be a non-zero multiple of DIGIT");
        end
    endgenerate

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e            state_q, state_d;
    logic [WIDTH-1:0]  a_q, a_d;
    logic [WIDTH-1:0]  b_q, b_d;
    logic [WIDTH-1:0]  acc_q, acc_d;
    logic              carry_q, carry_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic              a_msb_q, a_msb_d;
    logic              b_msb_q, b_msb_d;
    logic [WIDTH-1:0]  sum_q, sum_d;
    logic              cout_q, cout_d;
    logic              ovf_q, ovf_d;

    logic [DIGIT:0]    digit_sum;
    logic [WIDTH-1:0]  acc_next;
    logic              last_digit;

    always_comb begin
        digit_sum = {1'b0, a_q[DIGIT-1:0]} + {1'b0, b_q[DIGIT-1:0]}
                  + {{DIGIT{1'b0}}, carry_q};
        // New digit enters from the top so the LSB digit ends up at bit 0.
        acc_next = acc_q >> DIGIT;
        acc_next[WIDTH-1 -: DIGIT] = digit_sum[DIGIT-1:0];
        last_digit = (cnt_q == CntW'(N - 1));

        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        a_msb_d = a_msb_q;
        b_msb_d = b_msb_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;

        case (state_q)
            StIdle, StDone: begin
                if (bus.start) begin
                    a_d     = bus.a;
                    b_d     = bus.b;
                    carry_d = bus.cin;
                    cnt_d   = '0;
                    a_msb_d = bus.a[WIDTH-1];
                    b_msb_d = bus.b[WIDTH-1];
                    state_d = StRun;
                end else if (state_q == StDone) begin
                    state_d = StIdle;
                end
            end
            StRun: begin
                a_d     = a_q >> DIGIT;
                b_d     = b_q >> DIGIT;
                carry_d = digit_sum[DIGIT];
                acc_d   = acc_next;
                cnt_d   = cnt_q + CntW'(1);
                if (last_digit) begin
                    sum_d   = acc_next;
                    cout_d  = digit_sum[DIGIT];
                    ovf_d   = (a_msb_q == b_msb_q) && (acc_next[WIDTH-1] != a_msb_q);
                    state_d = StDone;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            a_msb_q <= 1'b0;
            b_msb_q <= 1'b0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
            a_msb_q <= a_msb_d;
            b_msb_q <= b_msb_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign bus.busy     = (state_q == StRun);
    assign bus.done     = (state_q == StDone);
    assign bus.sum      = sum_q;
    assign bus.cout     = cout_q;
    assign bus.overflow = ovf_q;
endmodule

// File: tb/tb_serial_add.sv
// Bench for serial_add: several width/digit configurations behind one selectable
// driver, with a queue of expected results checked on each done pulse.
module tb_serial_add;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [15:0] a_drv = '0;
    logic [15:0] b_drv = '0;
    logic        cin_drv = 1'b0;
    int          sel = 0;

    logic        o_busy, o_done, o_cout, o_ovf;
    logic [15:0] o_sum;

    int          errors = 0;
    int          checks = 0;
    time         first_err = 0;
    logic [17:0] sb[$];

    always #5 clk = ~clk;

    always @(errors) if (errors != 0 && first_err == 0) first_err = $time;

    serial_add_if #(.WIDTH(16)) if0 ();
    serial_add_if #(.WIDTH(16)) if1 ();
    serial_add_if #(.WIDTH(8))  if2 ();
    serial_add_if #(.WIDTH(8))  if3 ();
    serial_add_if #(.WIDTH(8))  if4 ();
    serial_add_if #(.WIDTH(8))  if5 ();
    serial_add_if #(.WIDTH(1))  if6 ();

    serial_add #(.WIDTH(16), .DIGIT(1)) u0 (.clk(clk), .rst(rst), .bus(if0));
    serial_add #(.WIDTH(16), .DIGIT(4)) u1 (.clk(clk), .rst(rst), .bus(if1));
    serial_add #(.WIDTH(8),  .DIGIT(1)) u2 (.clk(clk), .rst(rst), .bus(if2));
    serial_add #(.WIDTH(8),  .DIGIT(2)) u3 (.clk(clk), .rst(rst), .bus(if3));
    serial_add #(.WIDTH(8),  .DIGIT(4)) u4 (.clk(clk), .rst(rst), .bus(if4));
    serial_add #(.WIDTH(8),  .DIGIT(8)) u5 (.clk(clk), .rst(rst), .bus(if5));
    serial_add #(.WIDTH(1),  .DIGIT(1)) u6 (.clk(clk), .rst(rst), .bus(if6));

    assign if0.start = start && (sel == 0);
    assign if1.start = start && (sel == 1);
    assign if2.start = start && (sel == 2);
    assign if3.start = start && (sel == 3);
    assign if4.start = start && (sel == 4);
    assign if5.start = start && (sel == 5);
    assign if6.start = start && (sel == 6);
    assign if0.a = a_drv;      assign if0.b = b_drv;      assign if0.cin = cin_drv;
    assign if1.a = a_drv;      assign if1.b = b_drv;      assign if1.cin = cin_drv;
    assign if2.a = a_drv[7:0]; assign if2.b = b_drv[7:0]; assign if2.cin = cin_drv;
    assign if3.a = a_drv[7:0]; assign if3.b = b_drv[7:0]; assign if3.cin = cin_drv;
    assign if4.a = a_drv[7:0]; assign if4.b = b_drv[7:0]; assign if4.cin = cin_drv;
    assign if5.a = a_drv[7:0]; assign if5.b = b_drv[7:0]; assign if5.cin = cin_drv;
    assign if6.a = a_drv[0];   assign if6.b = b_drv[0];   assign if6.cin = cin_drv;

    always_comb begin
        o_busy = 1'b0; o_done = 1'b0; o_sum = '0; o_cout = 1'b0; o_ovf = 1'b0;
        case (sel)
            0: begin o_busy = if0.busy; o_done = if0.done; o_sum = if0.sum;
                     o_cout = if0.cout; o_ovf = if0.overflow; end
            1: begin o_busy = if1.busy; o_done = if1.done; o_sum = if1.sum;
                     o_cout = if1.cout; o_ovf = if1.overflow; end
            2: begin o_busy = if2.busy; o_done = if2.done; o_sum = {8'h00, if2.sum};
                     o_cout = if2.cout; o_ovf = if2.overflow; end
            3: begin o_busy = if3.busy; o_done = if3.done; o_sum = {8'h00, if3.sum};
                     o_cout = if3.cout; o_ovf = if3.overflow; end
            4: begin o_busy = if4.busy; o_done = if4.done; o_sum = {8'h00, if4.sum};
                     o_cout = if4.cout; o_ovf = if4.overflow; end
            5: begin o_busy = if5.busy; o_done = if5.done; o_sum = {8'h00, if5.sum};
                     o_cout = if5.cout; o_ovf = if5.overflow; end
            6: begin o_busy = if6.busy; o_done = if6.done; o_sum = {15'h0000, if6.sum};
                     o_cout = if6.cout; o_ovf = if6.overflow; end
            default: ;
        endcase
    end

    function automatic int width_of(input int s);
        case (s)
            0, 1:       return 16;
            2, 3, 4, 5: return 8;
            default:    return 1;
        endcase
    endfunction

    // Golden model: {overflow, cout, sum} zero-extended to 16 bits.
    function automatic logic [17:0] model(input int w, input logic [15:0] x, y,
                                          input logic c);
        logic [16:0] full;
        logic [15:0] m, s;
        logic        co, ov;
        m    = 16'((17'd1 << w) - 17'd1);
        full = {1'b0, x & m} + {1'b0, y & m} + {16'h0000, c};
        s    = full[15:0] & m;
        co   = full[w];
        ov   = (x[w-1] == y[w-1]) && (s[w-1] != x[w-1]);
        return {ov, co, s};
    endfunction

    // Drive a request in the current cycle and record its expected result.
    task automatic start_op(input logic [15:0] x, y, input logic c);
        a_drv = x; b_drv = y; cin_drv = c; start = 1'b1;
        sb.push_back(model(width_of(sel), x, y, c));
    endtask

    // Wait (bounded) for done; lat counts cycles after the start cycle.
    task automatic wait_done(input bit drop, output int lat, output bit tmo,
                             output bit busy_ok, output logic [17:0] res);
        lat = 0; tmo = 1'b1; busy_ok = 1'b1; res = 'x;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (drop && i == 1) start = 1'b0;
            if (o_done === 1'b1) begin
                lat = i; tmo = 1'b0; res = {o_ovf, o_cout, o_sum};
                if (o_busy !== 1'b0) busy_ok = 1'b0;
                break;
            end
            if (o_busy !== 1'b1) busy_ok = 1'b0;
        end
    endtask

    task automatic test_reset;
        logic [19:0] got;
        rst = 1'b1; sel = 0; start = 1'b1; a_drv = 16'h1111; b_drv = 16'h2222;
        repeat (2) @(negedge clk);
        checks++;
        if (o_busy !== 1'b0) begin
            errors++; $display("FAIL reset_wins_start: busy=%b want 0", o_busy);
        end
        start = 1'b0;
        for (int s = 0; s < 7; s++) begin
            sel = s; #1;
            got = {o_busy, o_done, o_ovf, o_cout, o_sum};
            checks++;
            if (got !== 20'h0) begin
                errors++; $display("FAIL reset_state[%0d]: got %h want 00000", s, got);
            end
        end
        sel = 0;
        @(negedge clk); rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic;
        int lat; bit tmo, bok; logic [17:0] res, exp;
        sel = 0;
        start_op(16'h1234, 16'h4321, 1'b0);
        wait_done(1'b1, lat, tmo, bok, res); exp = sb.pop_front();
        checks++;
        if (tmo || lat != 17) begin
            errors++; $display("FAIL basic_latency: got %0d want 17 (timeout=%b)", lat, tmo);
        end
        checks++;
        if (!bok) begin errors++; $display("FAIL basic_busy: busy pattern wrong want 1..16"); end
        checks++;
        if (res !== exp || exp !== 18'h05555) begin
            errors++; $display("FAIL basic_result: got %h want %h", res, exp);
        end
        @(negedge clk);
        checks++;
        if (o_done !== 1'b0 || o_sum !== 16'h5555) begin
            errors++; $display("FAIL done_pulse_hold: done=%b sum=%h want 0/5555", o_done, o_sum);
        end
    endtask

    task automatic test_carry_overflow;
        int lat; bit tmo, bok; logic [17:0] res, exp;
        sel = 0;
        start_op(16'hFFFF, 16'h0001, 1'b0);
        wait_done(1'b1, lat, tmo, bok, res); exp = sb.pop_front();
        checks++;
        if (tmo || res !== exp || exp !== 18'h10000) begin
            errors++; $display("FAIL carry_out: got %h want %h", res, exp);
        end
        @(negedge clk);
        start_op(16'h7FFF, 16'h0001, 1'b0);
        wait_done(1'b1, lat, tmo, bok, res); exp = sb.pop_front();
        checks++;
        if (tmo || res !== exp || exp !== 18'h28000) begin
            errors++; $display("FAIL signed_overflow: got %h want %h", res, exp);
        end
    endtask

    task automatic test_back_to_back;
        int lat; bit tmo, bok; logic [17:0] res, exp;
        sel = 1;
        @(negedge clk);
        start_op(16'h0000, 16'hFFFF, 1'b1);
        wait_done(1'b1, lat, tmo, bok, res); exp = sb.pop_front();
        checks++;
        if (tmo || lat != 5 || res !== exp || exp !== 18'h10000) begin
            errors++; $display("FAIL d4_first: lat=%0d res=%h want 5/%h", lat, res, exp);
        end
        start_op(16'h1234, 16'h0FFF, 1'b0);  // asserted during the done cycle
        wait_done(1'b1, lat, tmo, bok, res); exp = sb.pop_front();
        checks++;
        if (tmo || lat != 5 || res !== exp) begin
            errors++; $display("FAIL d4_back_to_back: lat=%0d res=%h want 5/%h", lat, res, exp);
        end
        sel = 0;
        @(negedge clk);
    endtask

    task automatic test_start_held;
        int lat, dones, first, second; bit tmo, bok; logic [17:0] res, exp;
        sel = 0; dones = 0; first = 0; second = 0;
        start_op(16'hA5C3, 16'h3C5A, 1'b0);
        for (int i = 1; i <= 34; i++) begin
            @(negedge clk);
            if (o_done === 1'b1) begin
                dones++;
                if (dones == 1) first = i; else second = i;
                res = {o_ovf, o_cout, o_sum}; exp = sb.pop_front();
                checks++;
                if (res !== exp) begin
                    errors++; $display("FAIL held_result: got %h want %h", res, exp);
                end
            end
            a_drv = 16'($urandom); b_drv = 16'($urandom);
            if (o_done === 1'b1) sb.push_back(model(16, a_drv, b_drv, cin_drv));
        end
        checks++;
        if (dones != 2 || first != 17 || second != 34) begin
            errors++;
            $display("FAIL held_done_count: dones=%0d at %0d,%0d want 2 at 17,34",
                     dones, first, second);
        end
        wait_done(1'b1, lat, tmo, bok, res); exp = sb.pop_front();
        checks++;
        if (tmo || lat != 17 || res !== exp) begin
            errors++; $display("FAIL held_last: lat=%0d res=%h want 17/%h", lat, res, exp);
        end
    endtask

    task automatic test_reset_abort;
        int lat, dones; bit tmo, bok; logic [17:0] res, exp; logic [19:0] got;
        sel = 0; dones = 0;
        @(negedge clk);
        start_op(16'h00FF, 16'h0F0F, 1'b1);
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            if (i == 1) start = 1'b0;
            if (i == 8) rst = 1'b1;
        end
        @(negedge clk);
        got = {o_busy, o_done, o_ovf, o_cout, o_sum};
        checks++;
        if (got !== 20'h0) begin
            errors++; $display("FAIL abort_state: got %h want 00000", got);
        end
        rst = 1'b0;
        sb.delete();
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (o_done !== 1'b0 || o_busy !== 1'b0) dones++;
        end
        checks++;
        if (dones != 0) begin
            errors++; $display("FAIL abort_quiet: %0d active cycles want 0", dones);
        end
        start_op(16'hBEEF, 16'h4111, 1'b1);
        wait_done(1'b1, lat, tmo, bok, res); exp = sb.pop_front();
        checks++;
        if (tmo || lat != 17 || res !== exp) begin
            errors++; $display("FAIL after_abort: lat=%0d res=%h want 17/%h", lat, res, exp);
        end
    endtask

    task automatic test_random;
        int lat, bad; bit tmo, bok; logic [17:0] res, exp;
        for (int s = 2; s <= 5; s++) begin
            sel = s; bad = 0;
            @(negedge clk);
            for (int k = 0; k < 250; k++) begin
                start_op(16'($urandom), 16'($urandom), 1'($urandom));
                wait_done(1'b1, lat, tmo, bok, res); exp = sb.pop_front();
                checks++;
                if (tmo || !bok || res !== exp) begin
                    errors++; bad++;
                    if (bad <= 5)
                        $display("FAIL random_w8_sel%0d: a=%h b=%h cin=%b got %h want %h",
                                 s, a_drv[7:0], b_drv[7:0], cin_drv, res, exp);
                end
            end
        end
    endtask

    task automatic test_w1_exhaustive;
        int lat; bit tmo, bok; logic [17:0] res, exp; logic [2:0] v;
        sel = 6;
        @(negedge clk);
        for (int k = 0; k < 8; k++) begin
            v = 3'(k);
            start_op({15'h0000, v[2]}, {15'h0000, v[1]}, v[0]);
            wait_done(1'b1, lat, tmo, bok, res); exp = sb.pop_front();
            checks++;
            if (tmo || lat != 2 || res !== exp) begin
                errors++;
                $display("FAIL w1_table[%0d]: lat=%0d got %h want %h", k, lat, res, exp);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_carry_overflow();
        test_back_to_back();
        test_start_held();
        test_reset_abort();
        test_random();
        test_w1_exhaustive();
        if (errors != 0) $display("first error at time %0t", first_err);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
